fft_frame_buf: RTL and testbench

FFT_FRAME_BUF -- requirements
Module: fft_frame_buf

---
 rtl/fas_pkg.sv | 20 ++
 rtl/frame_bank.sv | 42 ++++
 rtl/fft_frame_buf.sv | 154 +++++++++++++++
 tb/tb_fft_frame_buf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared FFT-path package: default sample/frame geometry, bank identifiers
// and the helper that locates sample k inside a packed frame word.
package fas_pkg;

    // Default sample width (Q7.8 two's complement) and samples per frame
    localparam int FAS_DATA_W    = 16;
    localparam int FAS_FRAME_LEN = 16;

    // Ping-pong bank identifier
    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_e;

    // LSB position of sample k in a packed frame of dw-bit samples
    function automatic int unsigned frame_lsb(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame bank: FRAME_LEN x DATA_W register array with a single write
// port and the whole frame presented as a packed word (k=0 at the LSBs).
// Contents are cleared only by the asynchronous reset.
module frame_bank
    import fas_pkg::*;
#(
    parameter int DATA_W    = FAS_DATA_W,
    parameter int FRAME_LEN = FAS_FRAME_LEN,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        i_we,
    input  logic [ADDR_W-1:0]           i_addr,
    input  logic [DATA_W-1:0]           i_data,
    output logic [DATA_W*FRAME_LEN-1:0] o_data
);

    logic [DATA_W-1:0] r_mem [FRAME_LEN];

    // Sample storage: cleared by reset, written one sample per accepted beat
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (i_we) begin
                r_mem[i_addr] <= i_data;
            end
        end
    end

    // Pack the register array into the frame word, oldest sample at the LSBs
    always_comb begin
        o_data = '0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            o_data[frame_lsb(k, DATA_W) +: DATA_W] = r_mem[k];
        end
    end

endmodule

// File: rtl/fft_frame_buf.sv
// Ping-pong frame buffer between the FIR output and the FFT input.
// Samples fill one bank while the other is offered to the FFT; a sample that
// arrives while the write bank is still full is dropped and flagged on ovf.
// Optional feature: define FRAME_BUF_DROP_CNT_EN to add the 8-bit saturating
// drop_cnt output counting dropped samples.
module fft_frame_buf
    import fas_pkg::*;
#(
    parameter int DATA_W    = FAS_DATA_W,
    parameter int FRAME_LEN = FAS_FRAME_LEN
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        clr,
    input  logic                        fir_valid_d,
    input  logic [DATA_W-1:0]           fir_d,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [DATA_W*FRAME_LEN-1:0] frame_data,
    output logic                        ovf
`ifdef FRAME_BUF_DROP_CNT_EN
    ,
    output logic [7:0]                  drop_cnt
`endif
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    // Frame state registers
    logic [1:0]       r_full;
    bank_e            r_wr_bank;
    bank_e            r_rd_bank;
    logic [CNT_W-1:0] r_wr_cnt;
    logic             r_ovf;

    // Decoded per-cycle events
    logic                        w_accept;
    logic                        w_drop;
    logic                        w_last;
    logic                        w_release;
    logic [1:0]                  w_we;
    logic [1:0]                  w_full_nxt;
    logic [DATA_W*FRAME_LEN-1:0] w_bank0_data;
    logic [DATA_W*FRAME_LEN-1:0] w_bank1_data;

    // Sample/handshake decode; clr suppresses both so the flush wins
    always_comb begin
        w_accept  = fir_valid_d & ~r_full[r_wr_bank] & ~clr;
        w_drop    = fir_valid_d &  r_full[r_wr_bank] & ~clr;
        w_last    = w_accept & (r_wr_cnt == CNT_W'(FRAME_LEN - 1));
        w_release = r_full[r_rd_bank] & frame_ready & ~clr;
        w_we[0]   = w_accept & (r_wr_bank == BANK_0);
        w_we[1]   = w_accept & (r_wr_bank == BANK_1);
    end

    // Full-flag update: a completed write and a release only ever touch
    // different banks (write needs full=0, release needs full=1)
    always_comb begin
        w_full_nxt = 2'b00;
        for (int b = 0; b < 2; b++) begin
            w_full_nxt[b] = (r_full[b] & ~(w_release & (r_rd_bank == bank_e'(b))))
                          | (w_last & (r_wr_bank == bank_e'(b)));
        end
    end

    // Frame control state: pointers, full flags and sticky overflow
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_full    <= 2'b00;
            r_wr_bank <= BANK_0;
            r_rd_bank <= BANK_0;
            r_wr_cnt  <= '0;
            r_ovf     <= 1'b0;
        end else if (clr) begin
            r_full    <= 2'b00;
            r_wr_bank <= BANK_0;
            r_rd_bank <= BANK_0;
            r_wr_cnt  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                r_wr_cnt <= w_last ? '0 : r_wr_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_wr_bank <= bank_e'(~r_wr_bank);
            end
            if (w_release) begin
                r_rd_bank <= bank_e'(~r_rd_bank);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    frame_bank #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (CNT_W)
    ) u_bank0 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_we   (w_we[0]),
        .i_addr (r_wr_cnt),
        .i_data (fir_d),
        .o_data (w_bank0_data)
    );

    frame_bank #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (CNT_W)
    ) u_bank1 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_we   (w_we[1]),
        .i_addr (r_wr_cnt),
        .i_data (fir_d),
        .o_data (w_bank1_data)
    );

    // Present the read bank; both sources are registers only
    always_comb begin
        frame_valid = r_full[r_rd_bank];
        case (r_rd_bank)
            BANK_0:  frame_data = w_bank0_data;
            BANK_1:  frame_data = w_bank1_data;
            default: frame_data = w_bank0_data;
        endcase
    end

    assign ovf = r_ovf;

`ifdef FRAME_BUF_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of dropped samples
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_drop_cnt <= 8'd0;
        end else if (clr) begin
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_drop && (r_drop_cnt != 8'd255)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fft_frame_buf.sv
// Directed bench for fft_frame_buf (DATA_W=16, FRAME_LEN=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_fft_frame_buf;

    logic         CLK;
    logic         RST_N;
    logic         clr;
    logic         fir_valid_d;
    logic [15:0]  fir_d;
    logic         frame_valid;
    logic         frame_ready;
    logic [255:0] frame_data;
    logic         ovf;
`ifdef FRAME_BUF_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    int n_checks;
    int n_fail;

    fft_frame_buf #(
        .DATA_W    (16),
        .FRAME_LEN (16)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .clr         (clr),
        .fir_valid_d (fir_valid_d),
        .fir_d       (fir_d),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .ovf         (ovf)
`ifdef FRAME_BUF_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wd(input int k);
        return frame_data[k*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One sample per call; consecutive calls give back-to-back samples
    task automatic send(input logic [15:0] v);
        fir_valid_d = 1'b1;
        fir_d       = v;
        tick();
        fir_valid_d = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        RST_N       = 1'b0;
        clr         = 1'b0;
        fir_valid_d = 1'b0;
        fir_d       = 16'h0000;
        frame_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {63'd0, frame_valid}, 64'd0);
        chk("rst_ovf",   {63'd0, ovf},         64'd0);
        chk("rst_data0", {48'd0, wd(0)},       64'd0);
        RST_N = 1'b1;
        tick();

        // Reset mid-frame after 7 samples, then a clean frame 1..16
        for (int i = 0; i < 7; i++) send(16'hAA00 + 16'(i));
        RST_N = 1'b0;
        #2;
        chk("midrst_valid", {63'd0, frame_valid}, 64'd0);
        chk("midrst_data0", {48'd0, wd(0)},       64'd0);
        tick();
        RST_N = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) send(16'(i));
        chk("r1_valid_before_last", {63'd0, frame_valid}, 64'd0);
        send(16'h0010);
        chk("r1_valid",  {63'd0, frame_valid}, 64'd1);
        chk("r1_word0",  {48'd0, wd(0)},       64'h0001);
        chk("r1_word15", {48'd0, wd(15)},      64'h0010);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("r1_released", {63'd0, frame_valid}, 64'd0);

        // Backpressure: 40 samples with no consumer
        flush();
        for (int i = 0; i < 40; i++) send(16'h0100 + 16'(i));
        chk("bp_ovf",    {63'd0, ovf},         64'd1);
        chk("bp_valid",  {63'd0, frame_valid}, 64'd1);
`ifdef FRAME_BUF_DROP_CNT_EN
        chk("bp_drop_cnt", {56'd0, drop_cnt},  64'd8);
`endif
        chk("bp_f0_word0",  {48'd0, wd(0)},  64'h0100);
        chk("bp_f0_word15", {48'd0, wd(15)}, 64'h010F);
        frame_ready = 1'b1;
        tick();
        chk("bp_f1_valid",  {63'd0, frame_valid}, 64'd1);
        chk("bp_f1_word0",  {48'd0, wd(0)},       64'h0110);
        chk("bp_f1_word15", {48'd0, wd(15)},      64'h011F);
        tick();
        frame_ready = 1'b0;
        chk("bp_empty", {63'd0, frame_valid}, 64'd0);

        // Streaming: ramp 0..63 with frame_ready held high
        flush();
        frame_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(16'(i));
            if ((i % 16) == 15) begin
                chk("st_valid", {63'd0, frame_valid}, 64'd1);
                chk("st_word0", {48'd0, wd(0)},       64'(i - 15));
                chk("st_word15", {48'd0, wd(15)},     64'(i));
            end else if ((i % 16) == 0) begin
                chk("st_gap", {63'd0, frame_valid}, 64'd0);
            end else begin
                fir_d = fir_d;
            end
        end
        chk("st_ovf", {63'd0, ovf}, 64'd0);
        tick();
        frame_ready = 1'b0;
        chk("st_drained", {63'd0, frame_valid}, 64'd0);

        // Concurrency: release of frame A in the same cycle as B's last sample
        flush();
        for (int i = 0; i < 16; i++) send(16'h0200 + 16'(i));
        for (int i = 0; i < 15; i++) send(16'h0300 + 16'(i));
        chk("cc_a_word0", {48'd0, wd(0)}, 64'h0200);
        frame_ready = 1'b1;
        send(16'h030F);
        frame_ready = 1'b0;
        chk("cc_valid",  {63'd0, frame_valid}, 64'd1);
        chk("cc_word0",  {48'd0, wd(0)},       64'h0300);
        chk("cc_word15", {48'd0, wd(15)},      64'h030F);
        chk("cc_ovf",    {63'd0, ovf},         64'd0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("cc_empty", {63'd0, frame_valid}, 64'd0);

        // Flush with a simultaneous sample after 5 samples
        for (int i = 0; i < 5; i++) send(16'h0400 + 16'(i));
        clr         = 1'b1;
        fir_valid_d = 1'b1;
        fir_d       = 16'h04FF;
        tick();
        clr         = 1'b0;
        fir_valid_d = 1'b0;
        chk("cl_valid", {63'd0, frame_valid}, 64'd0);
        // Ready while nothing is valid must not move the read pointer
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(16'h0500 + 16'(i));
        chk("cl_valid_before_last", {63'd0, frame_valid}, 64'd0);
        send(16'h050F);
        chk("cl_frame_valid", {63'd0, frame_valid}, 64'd1);
        chk("cl_word0",  {48'd0, wd(0)},  64'h0500);
        chk("cl_word15", {48'd0, wd(15)}, 64'h050F);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;

        // Sign: extreme negative values pass bit-exact
        flush();
        send(16'h8000);
        send(16'hFFFF);
        for (int i = 2; i < 16; i++) send(16'(i));
        chk("sg_valid", {63'd0, frame_valid}, 64'd1);
        chk("sg_word0", {48'd0, wd(0)},       64'h8000);
        chk("sg_word1", {48'd0, wd(1)},       64'hFFFF);
        chk("sg_word2", {48'd0, wd(2)},       64'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
